// File: rtl/riscp_pkg.sv
// Shared types and constants for the multi-cycle RISC controller.
// Also holds the Moore output decode so state/opcode meaning lives in one place.
package riscp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT,
    S_TRAP
  } state_e;

  localparam logic [2:0] CLS_RALU = 3'b000;
  localparam logic [2:0] CLS_IALU = 3'b001;
  localparam logic [2:0] CLS_LW   = 3'b010;
  localparam logic [2:0] CLS_SW   = 3'b011;
  localparam logic [2:0] CLS_BEQ  = 3'b100;
  localparam logic [2:0] CLS_JMP  = 3'b101;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_IMEM    = 2'b10;
  localparam logic [1:0] CAUSE_DMEM    = 2'b11;

  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef struct packed {
    logic       imemReq;
    logic       dmemReq;
    logic       dmemWe;
    logic [2:0] aluOpcode;
    logic       aluSrcImm;
    logic       regWriteEnable;
    logic       memToReg;
    logic       halted;
    logic       trap;
  } ctrl_t;

  function automatic logic isIllegal(input logic [5:0] op);
    return (op[5:3] inside {3'b110, 3'b111}) && (op != OP_HALT);
  endfunction

  // The ALU controls stay valid through EXEC, MEM and WB so the datapath
  // can hold its result/address without extra latching.
  function automatic ctrl_t ctrlFor(input state_e st, input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (st)
      S_FETCH: c.imemReq = 1'b1;
      S_EXEC, S_MEM, S_WB: begin
        case (op[5:3])
          CLS_RALU, CLS_IALU: begin
            c.aluOpcode = op[2:0];
            c.aluSrcImm = (op[5:3] == CLS_IALU);
          end
          CLS_LW, CLS_SW: begin
            c.aluOpcode = ALU_ADD;
            c.aluSrcImm = 1'b1;
          end
          CLS_BEQ: c.aluOpcode = ALU_SUB;
          default: c.aluOpcode = ALU_ADD;
        endcase
        if (st == S_MEM) begin
          c.dmemReq = 1'b1;
          c.dmemWe  = (op[5:3] == CLS_SW);
        end
        if (st == S_WB) begin
          c.regWriteEnable = 1'b1;
          c.memToReg       = (op[5:3] == CLS_LW);
        end
      end
      S_HALT:  c.halted = 1'b1;
      S_TRAP:  c.trap   = 1'b1;
      default: c.imemReq = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Wait-cycle counter for memory handshakes; expires on the TIMEOUT-th
// consecutive enabled cycle. TIMEOUT of 0 disables expiry.
module bus_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign expire_o = (TIMEOUT != 0) && enable_i && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle sequencer: owns PC, IR and the retired counter, and drives
// registered Moore control lines for the register-file/ALU datapath.
module multicycle_controller
  import riscp_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  input  logic        alu_zero,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic [2:0]  alu_opcode,
  output logic        alu_src_imm,
  output logic        reg_write_enable,
  output logic        mem_to_reg,
  output logic        halted,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] retired
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] retired_q, retired_d;
  logic [1:0]  trapCause_q, trapCause_d;
  ctrl_t       ctrl_q;

  logic        wdEnable;
  logic        wdExpire;
  logic [2:0]  opClass;
  logic [31:0] branchOffset;

  assign opClass      = ir_q[31:29];
  assign branchOffset = {{16{ir_q[15]}}, ir_q[15:0]};
  assign wdEnable     = ((state_q == S_FETCH) && !imem_ready) ||
                        ((state_q == S_MEM) && !dmem_ready);

  bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (state_d != state_q),
    .enable_i (wdEnable),
    .expire_o (wdExpire)
  );

  // Ready is tested before expiry so a transfer on the last allowed cycle wins.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    retired_d   = retired_q;
    trapCause_d = trapCause_q;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ready) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end else if (wdExpire) begin
          trapCause_d = CAUSE_IMEM;
          state_d     = S_TRAP;
        end
      end
      S_DECODE: begin
        pc_d = pc_q + 32'd1;
        if (isIllegal(ir_q[31:26])) begin
          trapCause_d = CAUSE_ILLEGAL;
          state_d     = S_TRAP;
        end else if (ir_q[31:26] == OP_HALT) begin
          state_d = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (opClass)
          CLS_LW, CLS_SW: state_d = S_MEM;
          CLS_BEQ: begin
            if (alu_zero) begin
              pc_d = pc_q + branchOffset;
            end
            retired_d = retired_q + 32'd1;
            state_d   = S_FETCH;
          end
          CLS_JMP: begin
            pc_d      = {pc_q[31:26], ir_q[25:0]};
            retired_d = retired_q + 32'd1;
            state_d   = S_FETCH;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (dmem_ready) begin
          if (opClass == CLS_SW) begin
            retired_d = retired_q + 32'd1;
            state_d   = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wdExpire) begin
          trapCause_d = CAUSE_DMEM;
          state_d     = S_TRAP;
        end
      end
      S_WB: begin
        retired_d = retired_q + 32'd1;
        state_d   = S_FETCH;
      end
      default: state_d = state_q;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      retired_q   <= '0;
      trapCause_q <= CAUSE_NONE;
      ctrl_q      <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      retired_q   <= retired_d;
      trapCause_q <= trapCause_d;
      ctrl_q      <= ctrlFor(state_d, ir_d[31:26]);
    end
  end

  assign imem_req         = ctrl_q.imemReq;
  assign dmem_req         = ctrl_q.dmemReq;
  assign dmem_we          = ctrl_q.dmemWe;
  assign alu_opcode       = ctrl_q.aluOpcode;
  assign alu_src_imm      = ctrl_q.aluSrcImm;
  assign reg_write_enable = ctrl_q.regWriteEnable;
  assign mem_to_reg       = ctrl_q.memToReg;
  assign halted           = ctrl_q.halted;
  assign trap             = ctrl_q.trap;
  assign pc               = pc_q;
  assign ir               = ir_q;
  assign retired          = retired_q;
  assign trap_cause       = trapCause_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: stimulus pushes per-instruction expectations from an
// instruction-level model; a monitor measures each instruction and compares.
module tb_multicycle_controller;

  localparam logic [31:0] RESET_PC = 32'h0000_0004;
  localparam int          TO       = 4;
  localparam logic [31:0] HALT_I   = {6'b111111, 26'd0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        dmem_req, dmem_we, dmem_ready = 1'b0;
  logic        alu_zero = 1'b0;
  logic [31:0] pc, ir, retired;
  logic [2:0]  alu_opcode;
  logic        alu_src_imm, reg_write_enable, mem_to_reg, halted, trap;
  logic [1:0]  trap_cause;

  multicycle_controller #(.RESET_PC(RESET_PC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .alu_zero(alu_zero), .pc(pc), .ir(ir),
    .alu_opcode(alu_opcode), .alu_src_imm(alu_src_imm),
    .reg_write_enable(reg_write_enable), .mem_to_reg(mem_to_reg),
    .halted(halted), .trap(trap), .trap_cause(trap_cause), .retired(retired)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    int          fw;
    int          dw;
    logic        zero;
  } prog_t;

  typedef struct {
    int          cycles;
    logic [31:0] pc;
    logic [31:0] retired;
    logic [31:0] ir;
    int          rwe;
    logic        m2r;
    int          dCyc;
    logic        dWe;
    logic        chkAlu;
    logic [2:0]  alu;
    logic        src;
    int          endKind;
    logic [1:0]  cause;
  } exp_t;

  prog_t progQ[$];
  exp_t  sbQ[$];
  int    testsRun = 0;
  int    testsFailed = 0;

  logic [31:0] mPc, mRet, mIr;
  bit          mDone;
  int          mEnd;
  logic [1:0]  mCause;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Instruction-level reference: latency and effects straight from the ISA rules.
  task automatic applyStimulus(input logic [31:0] instr, input int fw, input int dw, input logic zero);
    prog_t p;
    exp_t e;
    logic [5:0] op;
    logic [31:0] nextPc;
    int nF;
    p.instr = instr; p.fw = fw; p.dw = dw; p.zero = zero;
    progQ.push_back(p);
    op = instr[31:26];
    nF = fw + 1;
    e.rwe = 0; e.m2r = 1'b0; e.dCyc = 0; e.dWe = 1'b0; e.chkAlu = 1'b0;
    e.alu = 3'b000; e.src = 1'b0; e.endKind = 0; e.cause = 2'b00;
    if (fw >= TO) begin
      e.cycles = TO; e.endKind = 2; e.cause = 2'b10;
    end else begin
      mIr = instr;
      nextPc = mPc + 32'd1;
      mPc = nextPc;
      case (op[5:3])
        3'b000, 3'b001: begin
          e.cycles = nF + 3; e.rwe = 1; e.chkAlu = 1'b1;
          e.alu = op[2:0]; e.src = (op[5:3] == 3'b001);
          mRet++;
        end
        3'b010, 3'b011: begin
          e.chkAlu = 1'b1; e.alu = 3'b000; e.src = 1'b1;
          e.dWe = (op[5:3] == 3'b011);
          if (dw >= TO) begin
            e.cycles = nF + 2 + TO; e.dCyc = TO; e.endKind = 2; e.cause = 2'b11;
          end else begin
            e.dCyc = dw + 1;
            if (op[5:3] == 3'b010) begin
              e.cycles = nF + 4 + dw; e.rwe = 1; e.m2r = 1'b1;
            end else begin
              e.cycles = nF + 3 + dw;
            end
            mRet++;
          end
        end
        3'b100: begin
          e.cycles = nF + 2; e.chkAlu = 1'b1; e.alu = 3'b001;
          if (zero) mPc = nextPc + 32'($signed(instr[15:0]));
          mRet++;
        end
        3'b101: begin
          e.cycles = nF + 2;
          mPc = {nextPc[31:26], instr[25:0]};
          mRet++;
        end
        default: begin
          e.cycles = nF + 1;
          if (op == 6'b111111) e.endKind = 1;
          else begin e.endKind = 2; e.cause = 2'b01; end
        end
      endcase
    end
    e.pc = mPc; e.retired = mRet; e.ir = mIr;
    if (e.endKind != 0) begin
      mDone = 1'b1; mEnd = e.endKind; mCause = e.cause;
    end
    sbQ.push_back(e);
  endtask

  // Instruction memory responder: waits as planned, noise when idle.
  int    iWait, dWait, dPlan;
  bit    iBusy, dBusy;
  initial begin : imemResponder
    prog_t p;
    iBusy = 0; dPlan = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        iBusy = 0; imem_ready = 1'b0;
      end else begin
        if (iBusy && (imem_ready || !imem_req)) begin
          iBusy = 0; imem_ready = 1'b0;
        end
        if (!iBusy && imem_req) begin
          if (progQ.size() > 0) p = progQ.pop_front();
          else begin p.instr = HALT_I; p.fw = 0; p.dw = 0; p.zero = 1'b0; end
          iBusy = 1; iWait = p.fw; dPlan = p.dw; alu_zero = p.zero;
          imem_rdata = p.instr;
        end
        if (iBusy) begin
          imem_ready = (iWait == 0);
          if (iWait > 0) iWait--;
        end else begin
          imem_ready = ($urandom_range(0, 3) == 0);
        end
      end
    end
  end

  initial begin : dmemResponder
    dBusy = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        dBusy = 0; dmem_ready = 1'b0;
      end else begin
        if (dBusy && (dmem_ready || !dmem_req)) begin
          dBusy = 0; dmem_ready = 1'b0;
        end
        if (!dBusy && dmem_req) begin
          dBusy = 1; dWait = dPlan;
        end
        if (dBusy) begin
          dmem_ready = (dWait == 0);
          if (dWait > 0) dWait--;
        end else begin
          dmem_ready = ($urandom_range(0, 3) == 0);
        end
      end
    end
  end

  // Monitor: one record per instruction, delimited by fetch starts and halt/trap.
  bit   obOpen, prevReq, prevTerm;
  int   obCyc, obNF, obRwe, obDCyc, obAlu;
  logic obM2r, obDWe, obSrc;

  task automatic closeRecord();
    exp_t e;
    checkOutput("sb_pending", 32'(sbQ.size() > 0), 32'd1);
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      checkOutput("cycles", obCyc, e.cycles);
      checkOutput("pc", pc, e.pc);
      checkOutput("retired", retired, e.retired);
      checkOutput("ir", ir, e.ir);
      checkOutput("rwe_cycles", obRwe, e.rwe);
      if (e.rwe > 0) checkOutput("mem_to_reg", obM2r, e.m2r);
      checkOutput("dmem_req_cycles", obDCyc, e.dCyc);
      if (e.dCyc > 0) checkOutput("dmem_we", obDWe, e.dWe);
      if (e.chkAlu) begin
        checkOutput("alu_opcode", obAlu, e.alu);
        checkOutput("alu_src_imm", obSrc, e.src);
      end
      checkOutput("halted", halted, e.endKind == 1);
      checkOutput("trap", trap, e.endKind == 2);
      checkOutput("trap_cause", trap_cause, e.cause);
    end
  endtask

  initial begin : monitorProc
    logic term, startEv, endEv;
    obOpen = 0; prevReq = 0; prevTerm = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        obOpen = 0; prevReq = 0; prevTerm = 0;
      end else begin
        term    = halted | trap;
        startEv = imem_req & ~prevReq;
        endEv   = term & ~prevTerm;
        if (obOpen && (startEv || endEv)) begin
          closeRecord();
          obOpen = 0;
        end
        if (startEv) begin
          obOpen = 1; obCyc = 0; obNF = 0; obRwe = 0; obDCyc = 0; obAlu = -1;
          obM2r = 1'b0; obDWe = 1'b0; obSrc = 1'b0;
        end
        if (obOpen) begin
          obCyc++;
          if (imem_req) obNF++;
          if (reg_write_enable) begin obRwe++; obM2r = mem_to_reg; end
          if (dmem_req) begin obDCyc++; obDWe = dmem_we; end
          if (obCyc == obNF + 2) begin obAlu = int'(alu_opcode); obSrc = alu_src_imm; end
        end
        prevReq = imem_req; prevTerm = term;
      end
    end
  end

  task automatic beginEpisode();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    progQ.delete(); sbQ.delete();
    mPc = RESET_PC; mRet = '0; mIr = '0; mDone = 1'b0; mEnd = 0; mCause = 2'b00;
    checkOutput("rst_pc", pc, RESET_PC);
    checkOutput("rst_ir", ir, 32'd0);
    checkOutput("rst_retired", retired, 32'd0);
    checkOutput("rst_trap_cause", trap_cause, 32'd0);
    checkOutput("rst_bits", {imem_req, dmem_req, dmem_we, alu_src_imm, reg_write_enable,
                             mem_to_reg, halted, trap, alu_opcode}, 32'd0);
  endtask

  task automatic awaitEnd();
    int budget = 0;
    while (!(halted || trap) && budget < 3000) begin
      @(negedge clk); budget++;
    end
    checkOutput("episode_ended", 32'(halted || trap), 32'd1);
    repeat (4) @(negedge clk);
    checkOutput("sb_drained", sbQ.size(), 32'd0);
    checkOutput("frozen_reqs", {imem_req, dmem_req, reg_write_enable}, 32'd0);
    checkOutput("frozen_pc", pc, mPc);
    checkOutput("frozen_retired", retired, mRet);
    checkOutput("frozen_halted", halted, mEnd == 1);
    checkOutput("frozen_trap", trap, mEnd == 2);
    checkOutput("frozen_cause", trap_cause, mCause);
  endtask

  task automatic runEpisode();
    @(negedge clk); rst = 1'b0;
    awaitEnd();
  endtask

  function automatic int randWait();
    return ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 5));
  endfunction

  function automatic logic [31:0] randInstr();
    int r;
    logic [5:0] op;
    logic [25:0] low;
    r = $urandom_range(0, 99);
    low = 26'($urandom);
    if (r < 30)      op = {3'b000, 3'($urandom)};
    else if (r < 50) op = {3'b001, 3'($urandom)};
    else if (r < 60) op = {3'b010, 3'($urandom)};
    else if (r < 70) op = {3'b011, 3'($urandom)};
    else if (r < 82) op = {3'b100, 3'($urandom)};
    else if (r < 90) op = {3'b101, 3'($urandom)};
    else if (r < 95) op = 6'($urandom_range(48, 62));
    else             op = 6'b111111;
    return {op, low};
  endfunction

  initial begin : mainProc
    int budget;
    // ADD with zero-wait fetch, then HALT
    beginEpisode();
    applyStimulus(32'h0022_1800, 0, 0, 1'b0);
    applyStimulus(HALT_I, 0, 0, 1'b0);
    runEpisode();

    // LW with three dmem wait cycles, then SW
    beginEpisode();
    applyStimulus({6'b010000, 5'd1, 5'd2, 16'h0010}, 0, 3, 1'b0);
    applyStimulus({6'b011000, 5'd1, 5'd2, 16'h0020}, 1, 0, 1'b0);
    applyStimulus(HALT_I, 0, 0, 1'b0);
    runEpisode();

    // BEQ at pc=5 taken and not taken, JMP to reach pc=5
    beginEpisode();
    applyStimulus({6'b101000, 26'd5}, 0, 0, 1'b0);
    applyStimulus({6'b100000, 5'd1, 5'd2, 16'hFFFE}, 0, 0, 1'b1);
    applyStimulus({6'b101000, 26'd5}, 0, 0, 1'b0);
    applyStimulus({6'b100000, 5'd1, 5'd2, 16'hFFFE}, 0, 0, 1'b0);
    applyStimulus(HALT_I, 0, 0, 1'b0);
    runEpisode();

    // Illegal opcode after one retired instruction
    beginEpisode();
    applyStimulus({6'b001000, 26'h0000123}, 0, 0, 1'b0);
    applyStimulus({6'b110000, 26'h0000123}, 0, 0, 1'b0);
    runEpisode();

    // Fetch watchdog: ready on the expiry cycle succeeds, one cycle later traps
    beginEpisode();
    applyStimulus(32'h0022_1800, TO - 1, 0, 1'b0);
    applyStimulus(32'h0022_1800, TO, 0, 1'b0);
    runEpisode();

    // Data watchdog expiry on a store
    beginEpisode();
    applyStimulus({6'b011000, 26'h0}, 0, TO, 1'b0);
    runEpisode();

    // Reset pulsed while a load holds dmem_req
    beginEpisode();
    applyStimulus({6'b010000, 26'h0}, 0, 3, 1'b0);
    applyStimulus(HALT_I, 0, 0, 1'b0);
    @(negedge clk); rst = 1'b0;
    budget = 0;
    while (!dmem_req && budget < 100) begin @(negedge clk); budget++; end
    checkOutput("mid_mem_reached", dmem_req, 1'b1);
    @(negedge clk); #2 rst = 1'b1; #1;
    checkOutput("async_dmem_req_drop", dmem_req, 1'b0);
    checkOutput("async_rwe", reg_write_enable, 1'b0);
    checkOutput("async_pc", pc, RESET_PC);
    checkOutput("async_retired", retired, 32'd0);
    @(negedge clk);
    progQ.delete(); sbQ.delete();
    mPc = RESET_PC; mRet = '0; mIr = '0; mDone = 1'b0; mEnd = 0; mCause = 2'b00;
    applyStimulus(32'h0022_1800, 0, 0, 1'b0);
    applyStimulus(HALT_I, 0, 0, 1'b0);
    @(negedge clk); rst = 1'b0;
    checkOutput("idle_after_rst", imem_req, 1'b0);
    @(posedge clk); #1;
    checkOutput("fetch_resumes", imem_req, 1'b1);
    awaitEnd();

    // Randomized programs
    for (int ep = 0; ep < 60; ep++) begin
      beginEpisode();
      for (int n = 0; n < 30 && !mDone; n++)
        applyStimulus(randInstr(), randWait(), randWait(), 1'($urandom_range(0, 1)));
      if (!mDone) applyStimulus(HALT_I, 0, 0, 1'b0);
      runEpisode();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle sequencer for the 32-bit RISC datapath.
- Owns the program counter and the instruction register.
- Fetches each instruction over a req/ready handshake and steps it through decode, execute, memory and writeback.
- Drives the datapath control lines: register-file write enable, ALU opcode, operand select, memory strobes.
- Sits between instruction/data memory interfaces and the register-file/ALU datapath.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- TIMEOUT, 255, maximum wait cycles for imem_ready/dmem_ready before trapping; 0 disables the watchdog

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- imem_req  out  1  instruction fetch request
- imem_ready  in  1  fetch complete; imem_rdata valid
- imem_rdata  in  32  fetched instruction
- dmem_req  out  1  data access request
- dmem_we  out  1  1=store, 0=load; valid while dmem_req
- dmem_ready  in  1  data access complete
- alu_zero  in  1  ALU zero flag
- pc  out  32  current PC (word address)
- ir  out  32  latched instruction; fields [31:26] op, [25:21] rs, [20:16] rt, [15:11] rd, [15:0] imm16, [25:0] target
- alu_opcode  out  3  ALU operation
- alu_src_imm  out  1  ALU operand2 = sign-extended imm16
- reg_write_enable  out  1  register-file write strobe
- mem_to_reg  out  1  writeback source = load data
- halted  out  1  sticky, HALT executed
- trap  out  1  sticky, fault
- trap_cause  out  2  01 illegal opcode, 10 imem timeout, 11 dmem timeout
- retired  out  32  retired-instruction counter

## Operation
- Opcode classes by op[5:3]:
  - 000 R-ALU: rd ← rs op rt, alu_opcode=op[2:0]
  - 001 I-ALU: rt ← rs op sext(imm16)
  - 010 LW
  - 011 SW
  - 100 BEQ
  - 101 JMP
  - 111 with op[2:0]=111 is HALT
  - all other opcodes are illegal
- ALU codes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLL, 111 SRL. LW/SW use ADD with alu_src_imm=1; BEQ uses SUB.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP.
- Transitions:
  - IDLE → FETCH.
  - FETCH holds imem_req=1; when imem_ready is sampled high, ir←imem_rdata and go to DECODE.
  - DECODE: pc←pc+1 (mod 2^32). Illegal opcode → TRAP; HALT → HALT; otherwise → EXEC.
  - EXEC:
    - ALU classes → WB.
    - LW/SW → MEM.
    - BEQ: if alu_zero, pc←pc+sext(imm16) (pc already incremented); → FETCH.
    - JMP: pc←{pc[31:26],target}; → FETCH.
  - MEM holds dmem_req=1; when dmem_ready is sampled high, LW → WB and SW → FETCH.
  - WB: reg_write_enable=1 for exactly this cycle, mem_to_reg=1 for LW; → FETCH.
  - HALT and TRAP are terminal until reset.
- Outputs are Moore: each is a function of state and ir only.
- retired increments by 1 on leaving WB, on leaving MEM for SW, and on leaving EXEC for BEQ/JMP. HALT and trapping instructions are not counted. The counter wraps at 2^32.
- Watchdog: counts cycles in FETCH/MEM with ready low. When the count reaches TIMEOUT, go to TRAP with cause 10 or 11. The count clears on every state change.

## Timing
- Reset values: state IDLE, pc=RESET_PC, ir=0, retired=0, trap_cause=0. Every 1-bit output is 0.
- rst asserted mid-operation aborts immediately: imem_req and dmem_req drop asynchronously and no partial write is issued.
- Latency with zero-wait memory (ready in the same cycle as req):
  - R/I-ALU: 4 cycles (FETCH, DECODE, EXEC, WB).
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ/JMP: 3 cycles.
  - Each wait cycle adds 1.
- Handshakes:
  - req is held high until ready is sampled high.
  - req deasserts in the cycle after the transfer.
  - ready while req is low is ignored.
- Simultaneous events: ready arriving in the same cycle the watchdog expires counts as success and takes priority over the trap.

## Structure
- Package riscp_pkg holds:
  - the state enum;
  - opcode class constants;
  - ALU opcode constants;
  - trap cause codes;
  - the HALT opcode 6'b111111.
- One sub-module, bus_watchdog: a cycle counter with clear, enable and expire, parameterised by TIMEOUT.
- FSM, PC, IR and retired counter live in multicycle_controller.

## Test plan
- ADD r3=r1+r2 (ir 32'h0022_1800), zero-wait imem → reg_write_enable high only in cycle 4; alu_opcode=000; pc 0→1; retired=1.
- LW with dmem_ready delayed 3 cycles → dmem_req high for 4 cycles; mem_to_reg=1 in WB; total 8 cycles; dmem_we=0.
- BEQ imm16=16'hFFFE at pc=5 with alu_zero=1 → pc=4. Same with alu_zero=0 → pc=6. Neither asserts reg_write_enable.
- Opcode 6'b110000 → trap=1, trap_cause=01, pc=old+1, retired unchanged; outputs frozen until rst.
- imem_ready held low, TIMEOUT=4 → TRAP with cause 10 after 4 FETCH cycles, imem_req=0 afterwards. Repeat with ready arriving on the expiry cycle → no trap.
- rst pulsed mid-MEM (dmem_req=1) → dmem_req drops immediately; pc=RESET_PC; state IDLE; FETCH resumes one cycle after rst deasserts.
